// File: rtl/bin_to_bcd_pkg.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_pkg
// Shared definitions for the sequential binary-to-BCD converter.
//   state_e      : controller states (IDLE, SHIFT, DONE)
//   SIGN_MINUS   : 7-segment code shown in the sign position for negatives
//   SIGN_NONE    : sign code for non-negative results
//   DIGIT_BLANK  : digit code the segment decoder renders as an unlit digit
// ---------------------------------------------------------------------------
package bin_to_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [3:0] SIGN_MINUS  = 4'hA;
    localparam logic [3:0] SIGN_NONE   = 4'h0;
    localparam logic [3:0] DIGIT_BLANK = 4'hF;

endpackage

// File: rtl/bin_to_bcd_seq_add3.sv
// ---------------------------------------------------------------------------
// bcd_add3
// One shift-and-add-3 correction cell: a working digit of 5 or more gets 3
// added so that the following left shift carries correctly into the next
// decimal digit.
//   digit_i : working BCD digit before correction
//   digit_o : corrected digit
// ---------------------------------------------------------------------------
module bcd_add3 (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seq
// Sequential binary-to-BCD converter for the display path. One operand bit is
// folded into the BCD digit chain per clock (shift-and-add-3), so a
// conversion takes WIDTH cycles plus one DONE cycle.
//
// Parameters
//   WIDTH  : operand width, 2..64
//   DIGITS : number of BCD output digits, 1..20
// Ports
//   clock       : rising-edge clock
//   reset       : asynchronous active-high reset, aborts any conversion
//   start       : conversion request, sampled only while idle
//   binary      : operand, captured on the accepting edge
//   signed_mode : 1 = two's complement operand, 0 = unsigned
//   busy        : high while a conversion is in progress (SHIFT or DONE)
//   done        : one-cycle pulse when the result outputs have updated
//   bcd         : packed result digits, digit 0 (units) in bits [3:0]
//   sign        : SIGN_MINUS for a negative result, otherwise SIGN_NONE
//   negative    : result is negative
//   overflow    : magnitude needed more than DIGITS digits; bcd then holds
//                 the low DIGITS digits of the true value
// Configuration
//   BIN_TO_BCD_LEADING_BLANK_EN : when defined, digits above the most
//   significant non-zero digit are output as DIGIT_BLANK (digit 0 never is).
// ---------------------------------------------------------------------------
module bin_to_bcd_seq
    import bin_to_bcd_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      binary,
    input  logic                  signed_mode,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [3:0]            sign,
    output logic                  negative,
    output logic                  overflow
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam int BCD_W = 4 * DIGITS;

    state_e             state_q,    state_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic [WIDTH-1:0]   mag_q,      mag_d;
    logic               neg_q,      neg_d;
    logic [BCD_W-1:0]   work_q,     work_d;
    logic               ovf_q,      ovf_d;
    logic [BCD_W-1:0]   bcd_q,      bcd_d;
    logic [3:0]         sign_q,     sign_d;
    logic               negative_q, negative_d;
    logic               overflow_q, overflow_d;

    // Digit chain after the add-3 correction and after the one-bit shift.
    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   work_shift;
    logic               carry_out;
    logic [BCD_W-1:0]   disp_bcd;

    for (genvar k = 0; k < DIGITS; k++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_i (work_q[4*k +: 4]),
            .digit_o (adj[4*k +: 4])
        );
    end

    assign work_shift = {adj[BCD_W-2:0], mag_q[cnt_q]};
    assign carry_out  = adj[BCD_W-1];

`ifdef BIN_TO_BCD_LEADING_BLANK_EN
    logic leading;

    // Walk down from the top digit blanking zeros until the first non-zero
    // digit; digit 0 is excluded so a zero result still shows "0".
    always_comb begin
        disp_bcd = work_shift;
        leading  = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (leading && (work_shift[4*k +: 4] == 4'h0)) begin
                disp_bcd[4*k +: 4] = DIGIT_BLANK;
            end else begin
                leading = 1'b0;
            end
        end
    end
`else
    assign disp_bcd = work_shift;
`endif

    // NOTE: every signal written here gets its hold value first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mag_d      = mag_q;
        neg_d      = neg_q;
        work_d     = work_q;
        ovf_d      = ovf_q;
        bcd_d      = bcd_q;
        sign_d     = sign_q;
        negative_d = negative_q;
        overflow_d = overflow_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (signed_mode && binary[WIDTH-1]) begin
                        mag_d = ~binary + WIDTH'(1);
                        neg_d = 1'b1;
                    end else begin
                        mag_d = binary;
                        neg_d = 1'b0;
                    end
                    work_d  = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = CNT_W'(WIDTH - 1);
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                work_d = work_shift;
                ovf_d  = ovf_q | carry_out;
                if (cnt_q == '0) begin
                    // The result registers load on the edge that enters DONE,
                    // so they change together with the rise of done.
                    bcd_d      = disp_bcd;
                    overflow_d = ovf_q | carry_out;
                    negative_d = neg_q;
                    sign_d     = neg_q ? SIGN_MINUS : SIGN_NONE;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its next value from the same pre-edge snapshot.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mag_q      <= '0;
            neg_q      <= 1'b0;
            work_q     <= '0;
            ovf_q      <= 1'b0;
            bcd_q      <= '0;
            sign_q     <= SIGN_NONE;
            negative_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mag_q      <= mag_d;
            neg_q      <= neg_d;
            work_q     <= work_d;
            ovf_q      <= ovf_d;
            bcd_q      <= bcd_d;
            sign_q     <= sign_d;
            negative_q <= negative_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign bcd      = bcd_q;
    assign sign     = sign_q;
    assign negative = negative_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_bin_to_bcd_seq
// Self-checking bench for bin_to_bcd_seq. Two instances share stimulus: a
// 32-bit / 10-digit converter and a 32-bit / 3-digit converter (overflow).
// Expected results are hand-computed decimal values written as BCD hex.
// ---------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

    localparam int WIDTH = 32;

    logic               clock;
    logic               reset;
    logic               start;
    logic [WIDTH-1:0]   binary;
    logic               signed_mode;

    logic               busy,  done,  negative,  overflow;
    logic [39:0]        bcd;
    logic [3:0]         sign;

    logic               busy3, done3, negative3, overflow3;
    logic [11:0]        bcd3;
    logic [3:0]         sign3;

    int checks   = 0;
    int failures = 0;

    logic [39:0] last_bcd;

    bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(10)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .binary      (binary),
        .signed_mode (signed_mode),
        .busy        (busy),
        .done        (done),
        .bcd         (bcd),
        .sign        (sign),
        .negative    (negative),
        .overflow    (overflow)
    );

    bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(3)) dut3 (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .binary      (binary),
        .signed_mode (signed_mode),
        .busy        (busy3),
        .done        (done3),
        .bcd         (bcd3),
        .sign        (sign3),
        .negative    (negative3),
        .overflow    (overflow3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        sm;
        logic [31:0] bin;
        logic [39:0] exp_bcd;
        logic        exp_neg;
        logic [11:0] exp3_bcd;
        logic        exp3_ovf;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Leading-zero blanking expected from the display option, n digits wide.
    function automatic logic [79:0] blank(input logic [79:0] v, input int n);
        logic [79:0] r;
        r = v;
`ifdef BIN_TO_BCD_LEADING_BLANK_EN
        begin
            logic lead;
            lead = 1'b1;
            for (int k = n - 1; k >= 1; k--) begin
                if (lead && (r[4*k +: 4] == 4'h0)) r[4*k +: 4] = 4'hF;
                else lead = 1'b0;
            end
        end
`endif
        return r;
    endfunction

    // Starts at a falling edge with the DUT idle; ends at a falling edge in
    // IDLE so the next call is accepted back-to-back.
    task automatic convert(input string tag, input vec_t v);
        int n;
        start       = 1'b1;
        binary      = v.bin;
        signed_mode = v.sm;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        check({tag, " busy_after_accept"}, busy, 1'b1);
        check({tag, " hold_while_busy"}, bcd, last_bcd);
        n = 1;
        while (!done && n < WIDTH + 8) begin
            @(negedge clock);
            if (!done) n++;
        end
        check({tag, " latency"}, n, WIDTH);
        check({tag, " bcd"}, bcd, blank({40'h0, v.exp_bcd}, 10));
        check({tag, " negative"}, negative, v.exp_neg);
        check({tag, " sign"}, sign, v.exp_neg ? 4'hA : 4'h0);
        check({tag, " overflow"}, overflow, 1'b0);
        check({tag, " bcd3"}, bcd3, blank({68'h0, v.exp3_bcd}, 3));
        check({tag, " overflow3"}, overflow3, v.exp3_ovf);
        last_bcd = 40'(blank({40'h0, v.exp_bcd}, 10));
        @(negedge clock);
        check({tag, " done_drops"}, done, 1'b0);
        check({tag, " idle_after"}, busy, 1'b0);
    endtask

    initial begin
        int ndone;
        vec_t v;

        vecs[0]  = '{1'b0, 32'd0,          40'h0000000000, 1'b0, 12'h000, 1'b0};
        vecs[1]  = '{1'b0, 32'd255,        40'h0000000255, 1'b0, 12'h255, 1'b0};
        vecs[2]  = '{1'b1, 32'hFFFFFFFF,   40'h0000000001, 1'b1, 12'h001, 1'b0};
        vecs[3]  = '{1'b1, 32'h80000000,   40'h2147483648, 1'b1, 12'h648, 1'b1};
        vecs[4]  = '{1'b0, 32'hFFFFFFFF,   40'h4294967295, 1'b0, 12'h295, 1'b1};
        vecs[5]  = '{1'b0, 32'd42,         40'h0000000042, 1'b0, 12'h042, 1'b0};
        vecs[6]  = '{1'b1, 32'd12345678,   40'h0012345678, 1'b0, 12'h678, 1'b1};
        vecs[7]  = '{1'b1, 32'hFFFFFC18,   40'h0000001000, 1'b1, 12'h000, 1'b1};
        vecs[8]  = '{1'b1, 32'h7FFFFFFF,   40'h2147483647, 1'b0, 12'h647, 1'b1};
        vecs[9]  = '{1'b0, 32'h80000000,   40'h2147483648, 1'b0, 12'h648, 1'b1};
        vecs[10] = '{1'b0, 32'd99999,      40'h0000099999, 1'b0, 12'h999, 1'b1};
        vecs[11] = '{1'b0, 32'd1000,       40'h0000001000, 1'b0, 12'h000, 1'b1};
        vecs[12] = '{1'b0, 32'd999,        40'h0000000999, 1'b0, 12'h999, 1'b0};
        vecs[13] = '{1'b1, 32'hFFFFFFFB,   40'h0000000005, 1'b1, 12'h005, 1'b0};

        reset       = 1'b1;
        start       = 1'b0;
        binary      = '0;
        signed_mode = 1'b0;
        last_bcd    = '0;
        repeat (2) @(negedge clock);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset bcd", bcd, 40'h0);
        check("reset sign", sign, 4'h0);
        check("reset negative", negative, 1'b0);
        check("reset overflow", overflow, 1'b0);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 14; i++) begin
            convert($sformatf("vec%0d", i), vecs[i]);
        end

        // start pulses at E+5 and E+20 while busy must be ignored.
        start       = 1'b1;
        binary      = 32'd255;
        signed_mode = 1'b0;
        @(posedge clock);
        @(negedge clock);
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            start  = (k == 4) || (k == 19);
            binary = start ? 32'd777 : 32'd255;
            @(negedge clock);
            if (done) ndone++;
        end
        start = 1'b0;
        check("busy_start done_count", ndone, 1);
        check("busy_start bcd", bcd, blank({40'h0, 40'h0000000255}, 10));
        check("busy_start idle", busy, 1'b0);
        last_bcd = 40'(blank({40'h0, 40'h0000000255}, 10));

        // Reset mid-conversion aborts and clears outputs, no done follows.
        start       = 1'b1;
        binary      = 32'hFFFFFFFF;
        signed_mode = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b1;
        #1;
        check("midreset busy", busy, 1'b0);
        check("midreset done", done, 1'b0);
        check("midreset bcd", bcd, 40'h0);
        check("midreset sign", sign, 4'h0);
        check("midreset negative", negative, 1'b0);
        check("midreset overflow", overflow, 1'b0);
        check("midreset bcd3", bcd3, 12'h0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        ndone = 0;
        for (int k = 0; k < WIDTH + 6; k++) begin
            @(negedge clock);
            if (done || done3) ndone++;
        end
        check("midreset no_done", ndone, 0);
        check("midreset idle", busy, 1'b0);
        last_bcd = '0;

        v = '{1'b0, 32'd42, 40'h0000000042, 1'b0, 12'h042, 1'b0};
        convert("after_reset", v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
